// File: rtl/req_cond_pkg.sv
// rtl/req_cond_pkg.sv - shared defaults and settle-time helper for the request conditioner
package req_cond_pkg;

  localparam int unsigned DEFAULT_N          = 3;
  localparam int unsigned DEFAULT_DEBOUNCE_W = 16;

  // Number of consecutive differing samples needed before a new key level is accepted.
  function automatic int unsigned settle_cycles(input int unsigned debounce_w);
    return 32'd1 << debounce_w;
  endfunction

endpackage

// File: rtl/key_debouncer.sv
// rtl/key_debouncer.sv - one key channel: synchronizer, settle counter, stable level, press pulse
module key_debouncer
  import req_cond_pkg::*;
#(
  parameter int unsigned DEBOUNCE_W = DEFAULT_DEBOUNCE_W
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic pressed,
  output logic press
);

  logic [1:0]            sync_n;
  logic                  level;
  logic                  stable;
  logic [DEBOUNCE_W-1:0] count;
  logic                  pressed_d;

  // Two-flop synchronizer; reset parks it at the released (high) level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_n <= 2'b11;
    else     sync_n <= {sync_n[0], key_n};
  end

  assign level = ~sync_n[1];

  // Settle counter: any agreement restarts it, a full run of disagreement commits the new level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stable <= 1'b0;
      count  <= '0;
    end else if (level == stable) begin
      count  <= '0;
    end else if (count == {DEBOUNCE_W{1'b1}}) begin
      stable <= level;
      count  <= '0;
    end else begin
      count  <= count + 1'b1;
    end
  end

  // Registered debounced level plus its one-cycle-old copy for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pressed   <= 1'b0;
      pressed_d <= 1'b0;
    end else begin
      pressed   <= stable;
      pressed_d <= pressed;
    end
  end

  assign press = pressed & ~pressed_d;

endmodule

// File: rtl/req_debounce_latch.sv
// rtl/req_debounce_latch.sv - debounced key requests to a round-robin arbiter; REQ_STICKY_EN selects latched requests
module req_debounce_latch
  import req_cond_pkg::*;
#(
  parameter int unsigned N          = DEFAULT_N,
  parameter int unsigned DEBOUNCE_W = DEFAULT_DEBOUNCE_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] key_n,
  input  logic         ena,
  input  logic [N-1:0] gnt,
  output logic [N-1:0] req,
  output logic [N-1:0] pressed,
  output logic         overrun
);

  logic [N-1:0] press;

  for (genvar g = 0; g < N; g++) begin : g_key
    key_debouncer #(
      .DEBOUNCE_W (DEBOUNCE_W)
    ) u_key (
      .clk     (clk),
      .rst     (rst),
      .key_n   (key_n[g]),
      .pressed (pressed[g]),
      .press   (press[g])
    );
  end

`ifdef REQ_STICKY_EN
  logic [N-1:0] pending;
  logic [N-1:0] grant;

  assign grant = gnt & {N{ena}};

  // Pending latch: a press sets it (and beats a same-cycle grant), an enabled grant clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pending <= '0;
    else     pending <= press | (pending & ~grant);
  end

  // Sticky overrun: a press landing on a still-pending channel that is not being granted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                              overrun <= 1'b0;
    else if (|(press & pending & ~grant)) overrun <= 1'b1;
  end

  assign req = pending;
`else
  logic unused_inputs;

  assign unused_inputs = ^{ena, gnt, press};
  assign req           = pressed;
  assign overrun       = 1'b0;
`endif

endmodule

// File: tb/tb_req_debounce_latch.sv
// tb/tb_req_debounce_latch.sv - randomized and directed bench for req_debounce_latch against a run-length model
module tb_req_debounce_latch;
  import req_cond_pkg::*;

  localparam int N      = 3;
  localparam int W      = 3;
  localparam int SETTLE = int'(settle_cycles(W));

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] key_n = '1;
  logic         ena = 1'b0;
  logic [N-1:0] gnt = '0;
  logic [N-1:0] req;
  logic [N-1:0] pressed;
  logic         overrun;

  int total = 0;
  int bad   = 0;

  // Reference model: a key level is accepted once SETTLE consecutive raw samples disagree
  // with the accepted level; the accepted level becomes visible on pressed three edges later.
  bit       mstable [N];
  int       mrun    [N];
  bit [2:0] hist    [N];
  bit       ep      [N];
  bit       ep_prev [N];
  bit       mpend   [N];
  bit       movr;

  req_debounce_latch #(.N(N), .DEBOUNCE_W(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .key_n   (key_n),
    .ena     (ena),
    .gnt     (gnt),
    .req     (req),
    .pressed (pressed),
    .overrun (overrun)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      mstable[i] = 0; mrun[i] = 0; hist[i] = '0;
      ep[i] = 0; ep_prev[i] = 0; mpend[i] = 0;
    end
    movr = 0;
  endtask

  function automatic logic [N-1:0] exp_pressed();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = ep[i];
    return v;
  endfunction

  function automatic logic [N-1:0] exp_req();
    logic [N-1:0] v;
`ifdef REQ_STICKY_EN
    for (int i = 0; i < N; i++) v[i] = mpend[i];
`else
    for (int i = 0; i < N; i++) v[i] = ep[i];
`endif
    return v;
  endfunction

  function automatic logic exp_ovr();
`ifdef REQ_STICKY_EN
    return movr;
`else
    return 1'b0;
`endif
  endfunction

  // Advance one clock: model consumes the inputs present at the edge; outputs settle 1ns later.
  task automatic tick();
    bit g;
    bit ev;
    bit samp;
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      for (int i = 0; i < N; i++) begin
        g  = ena && gnt[i];
        ev = ep[i] && !ep_prev[i];
        if (ev) begin
          if (mpend[i] && !g) movr = 1;
          mpend[i] = 1;
        end else if (g) begin
          mpend[i] = 0;
        end
        samp = ~key_n[i];
        mrun[i] = (samp != mstable[i]) ? mrun[i] + 1 : 0;
        if (mrun[i] == SETTLE) begin
          mstable[i] = samp;
          mrun[i] = 0;
        end
        ep_prev[i] = ep[i];
        ep[i]      = hist[i][2];
        hist[i]    = {hist[i][1:0], mstable[i]};
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    key_n = '1; ena = 0; gnt = '0;
    do_reset();
    total++; if (req !== '0) begin bad++; $display("FAIL reset_req: got %b want 000", req); end
    total++; if (pressed !== '0) begin bad++; $display("FAIL reset_pressed: got %b want 000", pressed); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun: got %b want 0", overrun); end
  endtask

  task automatic test_hold();
    do_reset();
    key_n = 3'b110;
    for (int k = 0; k <= 12; k++) begin
      tick();
      total++;
      if (pressed[0] !== (k >= SETTLE + 2)) begin
        bad++; $display("FAIL hold_pressed k=%0d: got %b want %b", k, pressed[0], (k >= SETTLE + 2));
      end
      total++;
      if (req !== exp_req()) begin
        bad++; $display("FAIL hold_req k=%0d: got %b want %b", k, req, exp_req());
      end
    end
`ifdef REQ_STICKY_EN
    total++; if (req[0] !== 1'b1) begin bad++; $display("FAIL hold_req_sticky: got %b want 1", req[0]); end
`endif
  endtask

  task automatic test_grant();
    for (int k = 13; k < 20; k++) tick();
    ena = 1; gnt = 3'b001;
    tick();
    ena = 0; gnt = '0;
    total++; if (req !== exp_req()) begin bad++; $display("FAIL grant_req: got %b want %b", req, exp_req()); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL grant_overrun: got %b want 0", overrun); end
`ifdef REQ_STICKY_EN
    total++; if (req[0] !== 1'b0) begin bad++; $display("FAIL grant_clear: got %b want 0", req[0]); end
`endif
    ena = 1; gnt = 3'b001;
    tick();
    ena = 0; gnt = 3'b001;
    for (int k = 0; k < 3; k++) begin
      tick();
      total++; if (req !== exp_req()) begin bad++; $display("FAIL grant_ena_low k=%0d: got %b want %b", k, req, exp_req()); end
    end
    gnt = '0;
  endtask

  task automatic test_glitch();
    do_reset();
    key_n = 3'b101;
    for (int k = 0; k < 25; k++) begin
      if (k == 5) key_n = 3'b111;
      tick();
      total++;
      if (pressed[1] !== 1'b0 || req[1] !== 1'b0) begin
        bad++; $display("FAIL glitch k=%0d: got pressed=%b req=%b want 0 0", k, pressed[1], req[1]);
      end
    end
    // A run of SETTLE-1 samples after a shorter glitch must still not commit.
    key_n = 3'b101; tick(); key_n = 3'b111; tick();
    key_n = 3'b101;
    for (int k = 0; k < SETTLE - 1; k++) tick();
    key_n = 3'b111;
    for (int k = 0; k < 6; k++) begin
      tick();
      total++; if (pressed !== exp_pressed() || pressed[1] !== 1'b0) begin
        bad++; $display("FAIL glitch_restart k=%0d: got %b want %b", k, pressed, exp_pressed());
      end
    end
  endtask

  task automatic test_overrun();
    do_reset();
    for (int p = 0; p < 2; p++) begin
      key_n = 3'b011;
      for (int k = 0; k < 13; k++) tick();
      key_n = 3'b111;
      for (int k = 0; k < 13; k++) tick();
    end
    total++; if (overrun !== exp_ovr()) begin bad++; $display("FAIL overrun: got %b want %b", overrun, exp_ovr()); end
`ifdef REQ_STICKY_EN
    total++; if (overrun !== 1'b1) begin bad++; $display("FAIL overrun_set: got %b want 1", overrun); end
`endif
    ena = 1; gnt = 3'b100;
    tick();
    ena = 0; gnt = '0;
    for (int k = 0; k < 5; k++) tick();
    total++; if (overrun !== exp_ovr()) begin bad++; $display("FAIL overrun_sticky: got %b want %b", overrun, exp_ovr()); end
  endtask

  task automatic test_simul_reset();
    do_reset();
    key_n = 3'b010;
    for (int k = 0; k < 12; k++) tick();
    total++; if (req !== 3'b101) begin bad++; $display("FAIL simul_req: got %b want 101", req); end
    for (int k = 12; k < 15; k++) tick();
    #2 rst = 1'b1;
    #1;
    model_reset();
    total++; if (req !== '0 || pressed !== '0 || overrun !== 1'b0) begin
      bad++; $display("FAIL async_reset: got req=%b pressed=%b ovr=%b want 0", req, pressed, overrun);
    end
    tick();
    key_n = 3'b111;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      total++; if (req !== '0 || pressed !== '0) begin
        bad++; $display("FAIL post_reset k=%0d: got req=%b pressed=%b want 0", k, req, pressed);
      end
    end
  endtask

  task automatic test_level();
    do_reset();
    key_n = 3'b110;
    for (int k = 0; k < 40; k++) begin
      if (k == 15) key_n = 3'b111;
      tick();
      total++; if (req !== exp_req() || overrun !== exp_ovr()) begin
        bad++; $display("FAIL level k=%0d: got req=%b ovr=%b want %b %b", k, req, overrun, exp_req(), exp_ovr());
      end
`ifndef REQ_STICKY_EN
      total++; if (req[0] !== pressed[0] || overrun !== 1'b0) begin
        bad++; $display("FAIL level_track k=%0d: got req=%b pressed=%b ovr=%b", k, req[0], pressed[0], overrun);
      end
`endif
    end
  endtask

  task automatic test_random();
    int remain [N];
    do_reset();
    for (int i = 0; i < N; i++) remain[i] = 0;
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (remain[i] == 0) begin
          key_n[i]  = 1'($urandom_range(0, 1));
          remain[i] = $urandom_range(1, 2 * SETTLE - 2);
        end
        remain[i]--;
      end
      ena = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 3))
        0: gnt = 3'b001;
        1: gnt = 3'b010;
        2: gnt = 3'b100;
        default: gnt = 3'b000;
      endcase
      tick();
      total++; if (pressed !== exp_pressed()) begin
        bad++; $display("FAIL rand_pressed c=%0d: got %b want %b", c, pressed, exp_pressed());
      end
      total++; if (req !== exp_req()) begin
        bad++; $display("FAIL rand_req c=%0d: got %b want %b", c, req, exp_req());
      end
      total++; if (overrun !== exp_ovr()) begin
        bad++; $display("FAIL rand_overrun c=%0d: got %b want %b", c, overrun, exp_ovr());
      end
    end
    ena = 0; gnt = '0; key_n = '1;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_hold();
    test_grant();
    test_glitch();
    test_overrun();
    test_simul_reset();
    test_level();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
